// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT input-path defaults and lane-order encoding.
package fft_pkg;
  localparam int FFT_WORDLENGTH = 16;
  localparam int FFT_LANES = 4;
  typedef enum logic {ORDER_NAT = 1'b0, ORDER_REV = 1'b1} order_e;
endpackage

// File: rtl/s2p_lanes_if.sv
// s2p_lanes_if: serial sample input, group output handshake and status of the s2p converter.
interface s2p_lanes_if #(
  parameter int WORDLENGTH = 16,
  parameter int LANES = 4
);
  localparam int CNT_W = $clog2(LANES);
  logic enable;
  logic sync;
  logic rev_mode;
  logic [WORDLENGTH-1:0] data_in;
  logic out_ready;
  logic clr_flags;
  logic [LANES*WORDLENGTH-1:0] data_out;
  logic out_valid;
  logic ovf;
  logic sync_err;
  logic [CNT_W-1:0] slot;
  modport master (
    output enable, sync, rev_mode, data_in, out_ready, clr_flags,
    input data_out, out_valid, ovf, sync_err, slot
  );
  modport slave (
    input enable, sync, rev_mode, data_in, out_ready, clr_flags,
    output data_out, out_valid, ovf, sync_err, slot
  );
endinterface

// File: rtl/s2p_lane_cnt.sv
// s2p_lane_cnt: lane counter with frame-sync realignment and sticky sync_err.
module s2p_lane_cnt #(
  parameter int LANES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic sync,
  input  logic clr_flags,
  output logic [$clog2(LANES)-1:0] wr_idx,
  output logic [$clog2(LANES)-1:0] slot,
  output logic done,
  output logic sync_err
);
  localparam int CNT_W = $clog2(LANES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sync_err_q, sync_err_d;
  always_comb begin
    wr_idx = sync ? '0 : cnt_q;
    done = enable & (wr_idx == CNT_W'(LANES - 1));
    cnt_d = enable ? wr_idx + 1'b1 : cnt_q;
    sync_err_d = (enable & sync & (|cnt_q)) | (sync_err_q & ~clr_flags);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sync_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sync_err_q <= sync_err_d;
    end
  end
  assign slot = cnt_q;
  assign sync_err = sync_err_q;
endmodule

// File: rtl/s2p_lanes.sv
// s2p_lanes: serial-to-parallel converter with run-time lane order and valid/ready group output.
module s2p_lanes
  import fft_pkg::*;
#(
  parameter int WORDLENGTH = FFT_WORDLENGTH,
  parameter int LANES = FFT_LANES
) (
  input logic clk,
  input logic rst,
  s2p_lanes_if.slave bus
);
  localparam int CNT_W = $clog2(LANES);
  logic [CNT_W-1:0] wr_idx, slot;
  logic done, load, sync_err;
  logic [LANES-1:0][WORDLENGTH-1:0] coll_q, coll_d, grp_nat, grp_rev, dout_q, dout_d;
  logic out_valid_q, out_valid_d, ovf_q, ovf_d;
  s2p_lane_cnt #(.LANES(LANES)) u_cnt (
    .clk(clk),
    .rst(rst),
    .enable(bus.enable),
    .sync(bus.sync),
    .clr_flags(bus.clr_flags),
    .wr_idx(wr_idx),
    .slot(slot),
    .done(done),
    .sync_err(sync_err)
  );
  always_comb begin
    coll_d = coll_q;
    if (bus.enable) coll_d[wr_idx] = bus.data_in;
  end
  // coll_d already holds the completing sample in the last slot
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign grp_nat[k] = coll_d[k];
    assign grp_rev[k] = coll_d[LANES-1-k];
  end
  always_comb begin
    load = done & (~out_valid_q | bus.out_ready);
    dout_d = !load ? dout_q : order_e'(bus.rev_mode) == ORDER_REV ? grp_rev : grp_nat;
    out_valid_d = load | (out_valid_q & ~bus.out_ready);
    ovf_d = (done & out_valid_q & ~bus.out_ready) | (ovf_q & ~bus.clr_flags);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coll_q <= '0;
      dout_q <= '0;
      out_valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      coll_q <= coll_d;
      dout_q <= dout_d;
      out_valid_q <= out_valid_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.data_out = dout_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ovf = ovf_q;
  assign bus.sync_err = sync_err;
  assign bus.slot = slot;
endmodule

// File: tb/tb_s2p_lanes.sv
// tb_s2p_lanes: LANES=4 and LANES=8 builds share one stimulus stream; each is scored against a queue-based model.
module tb_s2p_lanes;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0, sy = 1'b0, rev = 1'b0, rdy = 1'b1, clr = 1'b0;
  logic [15:0] din = '0;
  int checks = 0;
  int errors = 0;
  logic [63:0] last_grp = '0;

  always #5 clk = ~clk;

  s2p_lanes_if #(.WORDLENGTH(16), .LANES(4)) b4 ();
  s2p_lanes_if #(.WORDLENGTH(16), .LANES(8)) b8 ();
  s2p_lanes #(.WORDLENGTH(16), .LANES(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  s2p_lanes #(.WORDLENGTH(16), .LANES(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  assign b4.enable = en;    assign b8.enable = en;
  assign b4.sync = sy;      assign b8.sync = sy;
  assign b4.rev_mode = rev; assign b8.rev_mode = rev;
  assign b4.data_in = din;  assign b8.data_in = din;
  assign b4.out_ready = rdy; assign b8.out_ready = rdy;
  assign b4.clr_flags = clr; assign b8.clr_flags = clr;

  logic [127:0] w_dout[2];
  logic w_val[2], w_ovf[2], w_serr[2];
  logic [2:0] w_slot[2];
  assign w_dout[0] = {64'b0, b4.data_out};
  assign w_dout[1] = b8.data_out;
  assign w_val[0] = b4.out_valid;  assign w_val[1] = b8.out_valid;
  assign w_ovf[0] = b4.ovf;        assign w_ovf[1] = b8.ovf;
  assign w_serr[0] = b4.sync_err;  assign w_serr[1] = b8.sync_err;
  assign w_slot[0] = {1'b0, b4.slot};
  assign w_slot[1] = b8.slot;

  // Reference: a partial group is just the list of samples since the last wrap or sync.
  logic [15:0] part[2][$];
  logic [127:0] expq[2][$];
  bit m_val[2], m_ovf[2], m_serr[2];

  task automatic chk(input string nm, input int inst, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[L%0d] got %h expected %h at %0t", nm, inst ? 8 : 4, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    int l;
    bit done, ovf_set, serr_set;
    logic [127:0] g;
    l = i ? 8 : 4;
    done = 0; ovf_set = 0; serr_set = 0; g = '0;
    if (en) begin
      if (sy) begin
        serr_set = part[i].size() != 0;
        part[i].delete();
      end
      part[i].push_back(din);
      if (part[i].size() == l) begin
        done = 1;
        for (int k = 0; k < l; k++) g[k*16 +: 16] = rev ? part[i][l-1-k] : part[i][k];
        part[i].delete();
      end
    end
    if (done && m_val[i] && !rdy) ovf_set = 1;
    else if (done) expq[i].push_back(g);
    m_val[i] = (done && !ovf_set) || (m_val[i] && !rdy);
    m_ovf[i] = ovf_set || (m_ovf[i] && !clr);
    m_serr[i] = serr_set || (m_serr[i] && !clr);
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        part[i].delete();
        expq[i].delete();
        m_val[i] = 0; m_ovf[i] = 0; m_serr[i] = 0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("out_valid", i, 128'(w_val[i]), 128'(m_val[i]));
      chk("ovf", i, 128'(w_ovf[i]), 128'(m_ovf[i]));
      chk("sync_err", i, 128'(w_serr[i]), 128'(m_serr[i]));
      chk("slot", i, 128'(w_slot[i]), 128'(part[i].size()));
      if (w_val[i]) begin
        if (expq[i].size() == 0) chk("group_pending", i, 128'(1), 128'(0));
        else begin
          chk("data_out", i, w_dout[i], expq[i][0]);
          if (rdy && rst) begin
            if (i == 0) last_grp = w_dout[0][63:0];
            void'(expq[i].pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit e, input bit s, input logic [15:0] d);
    en = e; sy = s; din = d;
    tick();
  endtask

  task automatic idle(input int n);
    en = 0; sy = 0;
    repeat (n) tick();
  endtask

  initial begin
    repeat (3) tick();
    rst = 1;
    tick();
    // natural order
    drive(1, 1, 1); drive(1, 0, 2); drive(1, 0, 3); drive(1, 0, 4);
    idle(3);
    chk("nat_group", 0, 128'(last_grp), 128'(64'h0004_0003_0002_0001));
    // reversed order with enable gaps
    clr = 1; idle(1); clr = 0;
    rev = 1;
    drive(1, 1, 5); drive(0, 0, 0); drive(1, 0, 6); drive(1, 0, 7); drive(0, 0, 0); drive(1, 0, 8);
    idle(3);
    chk("rev_group", 0, 128'(last_grp), 128'(64'h0005_0006_0007_0008));
    // backpressure and overflow
    rev = 0; rdy = 0;
    for (int v = 1; v <= 8; v++) drive(1, v == 1, 16'(v));
    idle(2);
    chk("ovf_set", 0, 128'(b4.ovf), 128'(1));
    rdy = 1; tick(); rdy = 0; tick();
    chk("valid_fell", 0, 128'(b4.out_valid), 128'(0));
    clr = 1; tick(); clr = 0; tick();
    chk("ovf_clr", 0, 128'(b4.ovf), 128'(0));
    // back-to-back with consumption
    rdy = 1;
    for (int v = 1; v <= 16; v++) drive(1, v == 1, 16'(v));
    idle(3);
    chk("b2b_last", 0, 128'(last_grp), 128'(64'h0010_000f_000e_000d));
    // misaligned sync
    clr = 1; idle(1); clr = 0;
    drive(1, 1, 20); drive(1, 0, 21);
    drive(1, 1, 9); drive(1, 0, 10); drive(1, 0, 11); drive(1, 0, 12);
    idle(3);
    chk("sync_err_dir", 0, 128'(b4.sync_err), 128'(1));
    chk("misalign_group", 0, 128'(last_grp), 128'(64'h000c_000b_000a_0009));
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rev = 1'($urandom_range(0, 1));
      rdy = $urandom_range(0, 9) < 7;
      clr = $urandom_range(0, 7) == 0;
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 16'($urandom));
    end
    rdy = 1; clr = 1; idle(3); clr = 0;
    // mid-group asynchronous reset
    drive(1, 1, 16'h0a01); drive(1, 0, 16'h0a02); drive(1, 0, 16'h0a03);
    en = 0;
    rst = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_dout", i, w_dout[i], '0);
      chk("rst_valid", i, 128'(w_val[i]), 128'(0));
      chk("rst_ovf", i, 128'(w_ovf[i]), 128'(0));
      chk("rst_serr", i, 128'(w_serr[i]), 128'(0));
      chk("rst_slot", i, 128'(w_slot[i]), 128'(0));
    end
    tick(); tick();
    rst = 1;
    tick();
    for (int v = 0; v < 8; v++) drive(1, 0, 16'(16'h0b00 + v));
    idle(3);
    chk("post_rst_slot", 1, 128'(b8.slot), 128'(0));
    chk("post_rst_idle", 1, 128'(expq[1].size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
